step_counter_ctrl: RTL and testbench

STEP_COUNTER_CTRL -- requirements
Module: step_counter_ctrl

---
 rtl/step_counter_ctrl.sv | 137 +++++++++++++
 tb/tb_step_counter_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_counter_ctrl.sv
// rtl/step_counter_ctrl.sv - job controller driving an external step counter
module step_counter_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] seed,
  input  logic [1:0] mode,
  input  logic [3:0] steps,
  input  logic [3:0] target,
  input  logic       target_en,
  input  logic [3:0] count,
  output logic       load,
  output logic [3:0] data_in,
  output logic       count_en,
  output logic [1:0] c,
  output logic       busy,
  output logic       done,
  output logic       hit
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] remaining_q, remaining_d;
  logic [3:0] seed_q, seed_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] target_q, target_d;
  logic       target_en_q, target_en_d;
  logic       hit_q, hit_d;

  logic       in_run;
  logic       match;

  // Early-stop compare against the fed-back counter value, only meaningful in RUN
  always_comb begin
    in_run = (state_q == RUN);
    match  = in_run & target_en_q & (count == target_q);
  end

  // Counter-facing strobes; abort suppresses them in the cycle it is seen
  always_comb begin
    load     = (state_q == LOAD) & ~abort;
    data_in  = (state_q == LOAD) ? seed_q : 4'd0;
    count_en = in_run & ~abort & ~match & (remaining_q != 4'd0);
    // The illegal step code is mapped to hold so the counter never sees it
    if (in_run) begin
      c = (mode_q == 2'b10) ? 2'b11 : mode_q;
    end else begin
      c = 2'b11;
    end
    busy = (state_q == LOAD) | in_run;
    done = (state_q == DONE);
    hit  = hit_q;
  end

  // Next-state and job-register update
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    seed_d      = seed_q;
    mode_d      = mode_q;
    target_d    = target_q;
    target_en_d = target_en_q;
    hit_d       = hit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          seed_d      = seed;
          mode_d      = mode;
          target_d    = target;
          target_en_d = target_en;
          remaining_d = steps;
          hit_d       = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (abort || (remaining_q == 4'd0)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          hit_d   = 1'b0;
          state_d = DONE;
        end else if (match) begin
          // Match wins over exhaustion: stop without issuing a step this cycle
          hit_d   = 1'b1;
          state_d = DONE;
        end else if (remaining_q != 4'd0) begin
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) begin
            state_d = DONE;
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and job registers; reset returns everything to an idle, empty job
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= 4'd0;
      seed_q      <= 4'd0;
      mode_q      <= 2'b11;
      target_q    <= 4'd0;
      target_en_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      seed_q      <= seed_d;
      mode_q      <= mode_d;
      target_q    <= target_d;
      target_en_q <= target_en_d;
      hit_q       <= hit_d;
    end
  end

endmodule

// File: tb/tb_step_counter_ctrl.sv
// tb/tb_step_counter_ctrl.sv - scoreboard bench for step_counter_ctrl
module tb_step_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] seed = 4'd0;
  logic [1:0] mode = 2'b00;
  logic [3:0] steps = 4'd0;
  logic [3:0] target = 4'd0;
  logic       target_en = 1'b0;
  logic [3:0] count = 4'd0;
  logic       load;
  logic [3:0] data_in;
  logic       count_en;
  logic [1:0] c;
  logic       busy;
  logic       done;
  logic       hit;

  step_counter_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed),
    .mode(mode), .steps(steps), .target(target), .target_en(target_en),
    .count(count), .load(load), .data_in(data_in), .count_en(count_en),
    .c(c), .busy(busy), .done(done), .hit(hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] seed;
    logic [1:0] c;
    logic [3:0] cnt;
    logic       hit;
    int         pulses;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   pulses = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Stand-in for the external step counter
  always @(posedge clk) begin
    if (load) count <= data_in;
    else if (count_en) begin
      case (c)
        2'b00:   count <= count + 4'd3;
        2'b01:   count <= count + 4'd1;
        default: count <= count;
      endcase
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: invariants every cycle, scoreboard pop on done
  always @(negedge clk) begin
    if (reset) begin
      if (load || count_en) check("load_en_excl", {31'd0, load & count_en}, 0);
      if (!load) check("data_in_idle", {28'd0, data_in}, 0);
      if (!busy) check("c_not_run", {30'd0, c}, 3);
      if (load) begin
        pulses = 0;
        if (exp_q.size() > 0) check("data_in_seed", {28'd0, data_in}, {28'd0, exp_q[0].seed});
      end
      if (count_en) begin
        pulses++;
        if (exp_q.size() > 0) check("c_step", {30'd0, c}, {30'd0, exp_q[0].c});
      end
      if (done) begin
        if (exp_q.size() == 0) check("spurious_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("final_count", {28'd0, count}, {28'd0, e.cnt});
          check("hit", {31'd0, hit}, {31'd0, e.hit});
          check("pulses", pulses, e.pulses);
          check("latency", cyc - start_cyc, e.lat);
        end
        done_cnt++;
      end
    end
  end

  function automatic exp_t model(input logic [3:0] s, input logic [1:0] m, input logic [3:0] n,
                                 input logic [3:0] t, input logic te);
    exp_t       e;
    logic [3:0] cnt;
    logic [3:0] stp;
    int         rem;
    e.seed = s;
    e.c    = (m == 2'b10) ? 2'b11 : m;
    stp    = (m == 2'b00) ? 4'd3 : (m == 2'b01) ? 4'd1 : 4'd0;
    cnt    = s;
    rem    = int'(n);
    e.hit  = 1'b0;
    e.pulses = 0;
    while (rem > 0) begin
      if (te && cnt == t) begin
        e.hit = 1'b1;
        break;
      end
      cnt = cnt + stp;
      e.pulses++;
      rem--;
    end
    e.cnt = cnt;
    e.lat = e.hit ? e.pulses + 2 : int'(n) + 1;
    return e;
  endfunction

  // Drive one start pulse; returns #1 after the sampling edge with inputs scrambled
  task automatic kick(input logic [3:0] s, input logic [1:0] m, input logic [3:0] n,
                      input logic [3:0] t, input logic te);
    @(negedge clk);
    seed = s; mode = m; steps = n; target = t; target_en = te; start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    seed = 4'($urandom); mode = 2'($urandom); steps = 4'($urandom);
    target = 4'($urandom); target_en = 1'($urandom);
  endtask

  task automatic wait_done();
    int d0;
    int t;
    d0 = done_cnt;
    t = 0;
    while (done_cnt == d0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_job(input logic [3:0] s, input logic [1:0] m, input logic [3:0] n,
                         input logic [3:0] t, input logic te);
    exp_q.push_back(model(s, m, n, t, te));
    kick(s, m, n, t, te);
    wait_done();
  endtask

  initial begin
    exp_t e;
    #2;
    check("rst_load", {31'd0, load}, 0);
    check("rst_count_en", {31'd0, count_en}, 0);
    check("rst_c", {30'd0, c}, 3);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_hit", {31'd0, hit}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    abort = 1'b1;
    @(negedge clk);
    check("abort_idle_ignored", {31'd0, busy}, 0);
    abort = 1'b0;

    run_job(4'd2, 2'b00, 4'd3, 4'd0, 1'b0);
    run_job(4'd0, 2'b01, 4'd10, 4'd4, 1'b1);
    check("hit_hold", {31'd0, hit}, 1);
    run_job(4'd9, 2'b10, 4'd2, 4'd0, 1'b0);
    run_job(4'd5, 2'b01, 4'd0, 4'd5, 1'b1);
    check("hit_cleared", {31'd0, hit}, 0);

    // Abort after the third step, with a stray start during RUN
    e.seed = 4'd1; e.c = 2'b01; e.cnt = 4'd4; e.hit = 1'b0; e.pulses = 3; e.lat = 5;
    exp_q.push_back(e);
    kick(4'd1, 2'b01, 4'd8, 4'd15, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    check("no_queued_start", {31'd0, busy}, 0);

    // Asynchronous reset in the middle of RUN
    exp_q.push_back(model(4'd3, 2'b01, 4'd8, 4'd0, 1'b0));
    kick(4'd3, 2'b01, 4'd8, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_load", {31'd0, load}, 0);
    check("mid_rst_count_en", {31'd0, count_en}, 0);
    check("mid_rst_c", {30'd0, c}, 3);
    check("mid_rst_data_in", {28'd0, data_in}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_job(4'd7, 2'b00, 4'd2, 4'd0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_job(4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
